// File: rtl/nvdla_fakeram_dp_arb.sv
// Zero-fill sequencer, two-client round-robin read arbiter (port A) and write pass-through (port B)
// for a fakeram-style 1R/1W macro. Define NVDLA_FAKERAM_ARB_BYPASS_EN for write-first collision forwarding.
module nvdla_fakeram_dp_arb #(
  parameter int AW            = 8,
  parameter int DW            = 64,
  parameter int INIT_ON_RESET = 1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  output logic          init_done,
  input  logic          rd0_req_valid,
  output logic          rd0_req_ready,
  input  logic [AW-1:0] rd0_req_addr,
  output logic          rd0_rsp_valid,
  output logic [DW-1:0] rd0_rsp_data,
  input  logic          rd1_req_valid,
  output logic          rd1_req_ready,
  input  logic [AW-1:0] rd1_req_addr,
  output logic          rd1_rsp_valid,
  output logic [DW-1:0] rd1_rsp_data,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  output logic          ram_cena,
  output logic [AW-1:0] ram_aa,
  input  logic [DW-1:0] ram_qa,
  output logic          ram_cenb,
  output logic [AW-1:0] ram_ab,
  output logic [DW-1:0] ram_db
);

  // state | meaning
  // INIT  | zero-filling the array through port B, all clients held off
  // RUN   | reads arbitrated onto port A, writes passed through on port B
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam state_t        RST_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;
  localparam logic [AW-1:0] CNT_MAX   = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          rr_q;
  logic          gnt_vld_q, gnt_id_q;
  logic          rsp_vld0_q, rsp_vld1_q;
  logic [DW-1:0] rsp_data0_q, rsp_data1_q;
  logic [DW-1:0] rd_data;

  logic run, wr_fire, coll0, coll1, elig0, elig1, gnt0, gnt1;

  // Outputs are gated by the reset pin so they show reset values while reset is held.
  assign run     = (state_q == RUN) && nvdla_core_rstn;
  assign wr_fire = run && wr_req_valid;
  assign coll0   = wr_fire && (rd0_req_addr == wr_req_addr);
  assign coll1   = wr_fire && (rd1_req_addr == wr_req_addr);

`ifdef NVDLA_FAKERAM_ARB_BYPASS_EN
  logic          byp_q;
  logic [DW-1:0] byp_data_q;
  logic          byp_hit;

  assign elig0   = run && rd0_req_valid;
  assign elig1   = run && rd1_req_valid;
  assign byp_hit = (gnt0 && coll0) || (gnt1 && coll1);
  assign rd_data = byp_q ? byp_data_q : ram_qa;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q <= byp_hit;
      if (byp_hit) byp_data_q <= wr_req_data;
    end
  end
`else
  assign elig0   = run && rd0_req_valid && !coll0;
  assign elig1   = run && rd1_req_valid && !coll1;
  assign rd_data = ram_qa;
`endif

  // rr_q names the client that wins when both are eligible.
  assign gnt0 = elig0 && (!elig1 || !rr_q);
  assign gnt1 = elig1 && (!elig0 || rr_q);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state_q <= RST_STATE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ram_cenb = 1'b1;
    ram_ab   = cnt_q;
    ram_db   = '0;
    if (state_q == INIT && cnt_q == CNT_MAX) state_d = RUN;
    if (nvdla_core_rstn) begin
      if (state_q == INIT) begin
        ram_cenb = 1'b0;
      end else begin
        ram_cenb = ~wr_req_valid;
        ram_ab   = wr_req_addr;
        ram_db   = wr_req_data;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      gnt_vld_q   <= 1'b0;
      gnt_id_q    <= 1'b0;
      rsp_vld0_q  <= 1'b0;
      rsp_vld1_q  <= 1'b0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      if (state_q == INIT && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (gnt0 || gnt1) rr_q <= gnt0;
      gnt_vld_q  <= gnt0 || gnt1;
      gnt_id_q   <= gnt1;
      rsp_vld0_q <= gnt_vld_q && !gnt_id_q;
      rsp_vld1_q <= gnt_vld_q && gnt_id_q;
      if (gnt_vld_q && !gnt_id_q) rsp_data0_q <= rd_data;
      if (gnt_vld_q && gnt_id_q)  rsp_data1_q <= rd_data;
    end
  end

  assign init_done     = (state_q == RUN);
  assign wr_req_ready  = run;
  assign rd0_req_ready = gnt0;
  assign rd1_req_ready = gnt1;
  assign ram_cena      = !(gnt0 || gnt1);
  assign ram_aa        = gnt1 ? rd1_req_addr : rd0_req_addr;
  assign rd0_rsp_valid = rsp_vld0_q;
  assign rd0_rsp_data  = rsp_data0_q;
  assign rd1_rsp_valid = rsp_vld1_q;
  assign rd1_rsp_data  = rsp_data1_q;

endmodule

// File: tb/tb_nvdla_fakeram_dp_arb.sv
// Scoreboard bench for nvdla_fakeram_dp_arb with a behavioural 1R/1W RAM model;
// expectations follow NVDLA_FAKERAM_ARB_BYPASS_EN when it is defined.
module tb_nvdla_fakeram_dp_arb;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          init_done;
  logic          rd0_req_valid, rd0_req_ready, rd0_rsp_valid;
  logic [AW-1:0] rd0_req_addr;
  logic [DW-1:0] rd0_rsp_data;
  logic          rd1_req_valid, rd1_req_ready, rd1_rsp_valid;
  logic [AW-1:0] rd1_req_addr;
  logic [DW-1:0] rd1_rsp_data;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          ram_cena, ram_cenb;
  logic [AW-1:0] ram_aa, ram_ab;
  logic [DW-1:0] ram_qa, ram_db;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] mem [256];

  nvdla_fakeram_dp_arb #(.AW(AW), .DW(DW), .INIT_ON_RESET(1)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .init_done      (init_done),
    .rd0_req_valid  (rd0_req_valid),
    .rd0_req_ready  (rd0_req_ready),
    .rd0_req_addr   (rd0_req_addr),
    .rd0_rsp_valid  (rd0_rsp_valid),
    .rd0_rsp_data   (rd0_rsp_data),
    .rd1_req_valid  (rd1_req_valid),
    .rd1_req_ready  (rd1_req_ready),
    .rd1_req_addr   (rd1_req_addr),
    .rd1_rsp_valid  (rd1_rsp_valid),
    .rd1_rsp_data   (rd1_rsp_data),
    .wr_req_valid   (wr_req_valid),
    .wr_req_ready   (wr_req_ready),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .ram_cena       (ram_cena),
    .ram_aa         (ram_aa),
    .ram_qa         (ram_qa),
    .ram_cenb       (ram_cenb),
    .ram_ab         (ram_ab),
    .ram_db         (ram_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: read returns pre-write contents; array starts with garbage so zero-fill matters.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'hA5A5_A5A5_A5A5_A5A5 ^ 64'(i);
    end else begin
      if (!ram_cenb) mem[ram_ab] <= ram_db;
      if (!ram_cena) ram_qa <= mem[ram_aa];
    end
  end

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      last0 = '0;
      last1 = '0;
    end else begin
      if (rd0_rsp_valid) begin
        if (q0.size() == 0) check(1'b0, "rd0_unexpected_rsp", rd0_rsp_data, '0);
        else begin
          e0 = q0.pop_front();
          check(rd0_rsp_data == e0.d, "rd0_data", rd0_rsp_data, e0.d);
          check(cyc == e0.due, "rd0_latency", 64'(cyc), 64'(e0.due));
          last0 = e0.d;
        end
      end else check(rd0_rsp_data == last0, "rd0_hold", rd0_rsp_data, last0);
      if (rd1_rsp_valid) begin
        if (q1.size() == 0) check(1'b0, "rd1_unexpected_rsp", rd1_rsp_data, '0);
        else begin
          e1 = q1.pop_front();
          check(rd1_rsp_data == e1.d, "rd1_data", rd1_rsp_data, e1.d);
          check(cyc == e1.due, "rd1_latency", 64'(cyc), 64'(e1.due));
          last1 = e1.d;
        end
      end else check(rd1_rsp_data == last1, "rd1_hold", rd1_rsp_data, last1);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check(init_done == 1'b0, {tag, "_init_done"}, 64'(init_done), 64'(0));
    check(!rd0_req_ready && !rd1_req_ready && !wr_req_ready, {tag, "_ready"},
          64'({rd0_req_ready, rd1_req_ready, wr_req_ready}), 64'(0));
    check(ram_cena && ram_cenb, {tag, "_cen"}, 64'({ram_cena, ram_cenb}), 64'(3));
    check(!rd0_rsp_valid && !rd1_rsp_valid, {tag, "_rsp_valid"}, 64'({rd0_rsp_valid, rd1_rsp_valid}), 64'(0));
    check(rd0_rsp_data == '0 && rd1_rsp_data == '0, {tag, "_rsp_data"}, rd0_rsp_data | rd1_rsp_data, '0);
  endtask

  // Called at posedge+1 right after reset release; checks up to 'limit' init cycles.
  task automatic check_init(input int limit);
    int n = 0;
    while (n < limit) begin
      @(negedge clk);
      if (init_done) break;
      check(!ram_cenb && ram_ab == n[AW-1:0] && ram_db == '0, "init_write", 64'(ram_ab), 64'(n));
      check(!wr_req_ready && !rd0_req_ready && !rd1_req_ready, "init_ready",
            64'({wr_req_ready, rd0_req_ready, rd1_req_ready}), 64'(0));
      n++;
    end
    if (limit > 256) check(n == 256 && init_done, "init_len", 64'(n), 64'(256));
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
    @(negedge clk);
    check(wr_req_ready && !ram_cenb && ram_ab == a && ram_db == d, "wr_port_b", ram_db, d);
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
  endtask

  task automatic do_rd(input bit c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    int waited = 0;
    @(posedge clk); #1;
    if (c) begin rd1_req_valid = 1'b1; rd1_req_addr = a; end
    else   begin rd0_req_valid = 1'b1; rd0_req_addr = a; end
    for (int i = 0; i < 8 && !got; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c ? rd1_req_ready : rd0_req_ready) begin
        got = 1'b1;
        waited = i;
        check(!ram_cena && ram_aa == a, "rd_port_a", 64'(ram_aa), 64'(a));
        if (c) q1.push_back('{d: d, due: cyc + 2});
        else   q0.push_back('{d: d, due: cyc + 2});
      end
    end
    check(got && waited == 0, "rd_grant", 64'(waited), 64'(0));
    @(posedge clk); #1;
    rd0_req_valid = 1'b0;
    rd1_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    bit exp0;
    rd0_req_valid = 1'b0; rd0_req_addr = '0;
    rd1_req_valid = 1'b0; rd1_req_addr = '0;
    wr_req_valid  = 1'b0; wr_req_addr  = '0; wr_req_data = '0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("rst");
    rstn = 1'b1;
    check_init(300);

    do_rd(1'b0, 8'h10, 64'h0);
    do_wr(8'h20, 64'hDEADBEEF_00000055);
    do_rd(1'b0, 8'h20, 64'hDEADBEEF_00000055);
    do_rd(1'b1, 8'h10, 64'h0);
    do_wr(8'h01, 64'h111);
    do_wr(8'h02, 64'h222);

    // Both clients streaming; pointer currently favours client 0.
    @(posedge clk); #1;
    rd0_req_valid = 1'b1; rd0_req_addr = 8'h01;
    rd1_req_valid = 1'b1; rd1_req_addr = 8'h02;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      exp0 = (i % 2 == 0);
      check(rd0_req_ready == exp0 && rd1_req_ready == !exp0, "rr_grant",
            64'({rd0_req_ready, rd1_req_ready}), 64'({exp0, !exp0}));
      check(!ram_cena && ram_aa == (exp0 ? 8'h01 : 8'h02), "rr_addr", 64'(ram_aa), 64'(exp0 ? 8'h01 : 8'h02));
      if (rd0_req_ready) q0.push_back('{d: 64'h111, due: cyc + 2});
      if (rd1_req_ready) q1.push_back('{d: 64'h222, due: cyc + 2});
    end
    @(posedge clk); #1;
    rd0_req_valid = 1'b0; rd1_req_valid = 1'b0;

    // Same-cycle write/read collision on rd1.
    @(posedge clk); #1;
    wr_req_valid = 1'b1; wr_req_addr = 8'h30; wr_req_data = 64'h1234;
    rd1_req_valid = 1'b1; rd1_req_addr = 8'h30;
    @(negedge clk);
`ifdef NVDLA_FAKERAM_ARB_BYPASS_EN
    check(rd1_req_ready && !ram_cena && ram_aa == 8'h30 && !ram_cenb, "coll_bypass_grant",
          64'({rd1_req_ready, ram_cena, ram_cenb}), 64'(3'b100));
    if (rd1_req_ready) q1.push_back('{d: 64'h1234, due: cyc + 2});
    @(posedge clk); #1;
    wr_req_valid = 1'b0; rd1_req_valid = 1'b0;
`else
    check(!rd1_req_ready && ram_cena && !ram_cenb, "coll_stall",
          64'({rd1_req_ready, ram_cena, ram_cenb}), 64'(3'b010));
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
    @(negedge clk);
    check(rd1_req_ready && !ram_cena && ram_aa == 8'h30, "coll_retry", 64'(rd1_req_ready), 64'(1));
    if (rd1_req_ready) q1.push_back('{d: 64'h1234, due: cyc + 2});
    @(posedge clk); #1;
    rd1_req_valid = 1'b0;
`endif

    // Collision on rd0 while rd1 reads elsewhere; pointer favours client 0.
    @(posedge clk); #1;
    wr_req_valid = 1'b1; wr_req_addr = 8'h30; wr_req_data = 64'h5678;
    rd0_req_valid = 1'b1; rd0_req_addr = 8'h30;
    rd1_req_valid = 1'b1; rd1_req_addr = 8'h40;
    @(negedge clk);
`ifdef NVDLA_FAKERAM_ARB_BYPASS_EN
    check(rd0_req_ready && !rd1_req_ready, "coll2_first", 64'({rd0_req_ready, rd1_req_ready}), 64'(2'b10));
    if (rd0_req_ready) q0.push_back('{d: 64'h5678, due: cyc + 2});
    @(posedge clk); #1;
    wr_req_valid = 1'b0; rd0_req_valid = 1'b0;
    @(negedge clk);
    check(rd1_req_ready && !rd0_req_ready, "coll2_second", 64'({rd0_req_ready, rd1_req_ready}), 64'(2'b01));
    if (rd1_req_ready) q1.push_back('{d: 64'h0, due: cyc + 2});
`else
    check(!rd0_req_ready && rd1_req_ready, "coll2_first", 64'({rd0_req_ready, rd1_req_ready}), 64'(2'b01));
    if (rd1_req_ready) q1.push_back('{d: 64'h0, due: cyc + 2});
    @(posedge clk); #1;
    wr_req_valid = 1'b0; rd1_req_valid = 1'b0;
    @(negedge clk);
    check(rd0_req_ready && !rd1_req_ready, "coll2_second", 64'({rd0_req_ready, rd1_req_ready}), 64'(2'b10));
    if (rd0_req_ready) q0.push_back('{d: 64'h5678, due: cyc + 2});
`endif
    @(posedge clk); #1;
    rd0_req_valid = 1'b0; rd1_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check(q0.size() == 0 && q1.size() == 0, "queues_drained_run", 64'(q0.size() + q1.size()), 64'(0));

    // Reset from RUN clears response data; then reset again mid-INIT at counter 100.
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    check_init(101);
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_mid_init");
    check(ram_ab == '0, "rst_mid_init_cnt", 64'(ram_ab), 64'(0));
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    check_init(300);
    do_rd(1'b0, 8'h20, 64'h0);
    do_rd(1'b1, 8'hFF, 64'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check(q0.size() == 0 && q1.size() == 0, "queues_drained_end", 64'(q0.size() + q1.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
